// File: rtl/demux2_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// demux2_stream : 1-to-2 valid/ready demultiplexer, one FIFO per output port
// Rev 1.0
// ----------------------------------------------------------------------------

module demux2_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         head_valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    occ;
  logic [WIDTH-1:0] last_pop;
  logic             push_ok;
  logic             pop_ok;

  assign full       = (occ == FULL_COUNT);
  assign head_valid = (occ != '0);
  assign count      = occ;
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & head_valid;

  // Empty FIFO presents the most recently popped beat rather than stale storage.
  assign head_data  = head_valid ? mem[rd_ptr] : last_pop;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      last_pop <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

module demux2_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             a_data,
  output logic                         a_valid,
  input  logic                         a_ready,
  output logic [WIDTH-1:0]             b_data,
  output logic                         b_valid,
  input  logic                         b_ready,
  output logic [$clog2(DEPTH+1)-1:0]   a_count,
  output logic [$clog2(DEPTH+1)-1:0]   b_count
);
  logic a_full;
  logic b_full;
  logic push_a;
  logic push_b;

  // Readiness depends only on occupancy, never on a same-cycle pop.
  assign in_ready = in_sel ? ~a_full : ~b_full;
  assign push_a   = in_valid & in_ready & in_sel;
  assign push_b   = in_valid & in_ready & ~in_sel;

  demux2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk        (clk),
    .rst        (rst),
    .push       (push_a),
    .push_data  (in_data),
    .pop        (a_ready),
    .head_data  (a_data),
    .head_valid (a_valid),
    .full       (a_full),
    .count      (a_count)
  );

  demux2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk        (clk),
    .rst        (rst),
    .push       (push_b),
    .push_data  (in_data),
    .pop        (b_ready),
    .head_data  (b_data),
    .head_valid (b_valid),
    .full       (b_full),
    .count      (b_count)
  );
endmodule

`default_nettype wire

// File: tb/tb_demux2_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_demux2_stream : directed + randomized bench with a queue-based reference
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_demux2_stream;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CW-1:0]    a_count;
  logic [CW-1:0]    b_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [WIDTH-1:0] last_a;
  logic [WIDTH-1:0] last_b;

  demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_a_valid"}, 32'(a_valid), 32'(qa.size() != 0));
    check({tag, "_a_data"},  a_data, (qa.size() != 0) ? qa[0] : last_a);
    check({tag, "_a_count"}, 32'(a_count), 32'(qa.size()));
    check({tag, "_b_valid"}, 32'(b_valid), 32'(qb.size() != 0));
    check({tag, "_b_data"},  b_data, (qb.size() != 0) ? qb[0] : last_b);
    check({tag, "_b_count"}, 32'(b_count), 32'(qb.size()));
  endtask

  // One clock: drive inputs, check in_ready, advance model and DUT, check outputs.
  task automatic step(input logic v, input logic s, input logic [31:0] d,
                      input logic ar, input logic br, input string tag);
    bit exp_rdy, pa, pb, push;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #1;
    exp_rdy = s ? (qa.size() != DEPTH) : (qb.size() != DEPTH);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
    pa   = ar && (qa.size() != 0);
    pb   = br && (qb.size() != 0);
    push = v && exp_rdy;
    @(posedge clk);
    if (pa) last_a = qa.pop_front();
    if (pb) last_b = qb.pop_front();
    if (push) begin
      if (s) qa.push_back(d);
      else   qb.push_back(d);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'($urandom_range(0, 1));
    in_data  = $urandom;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    @(posedge clk);
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;
    last_a = '0; last_b = '0;
    @(posedge clk);
    #1;
    do_reset("t1_reset");

    // Idle: in_ready high for both steering values
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, "t1_idle_sel1");
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "t1_idle_sel0");

    // One beat to each port
    step(1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b1, "t2_push_a");
    check("t2_a_data_direct", a_data, 32'h1111_1111);
    step(1'b1, 1'b0, 32'h2222_2222, 1'b1, 1'b1, "t2_push_b");
    check("t2_b_data_direct", b_data, 32'h2222_2222);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "t2_drain");

    // Fill A while its consumer stalls; B still accepts
    step(1'b1, 1'b1, 32'hA0, 1'b0, 1'b0, "t3_a0");
    step(1'b1, 1'b1, 32'hA1, 1'b0, 1'b0, "t3_a1");
    step(1'b1, 1'b1, 32'hA2, 1'b0, 1'b0, "t3_a2_refused");
    check("t3_a_count_full", 32'(a_count), 32'd2);
    step(1'b1, 1'b0, 32'hB0, 1'b0, 1'b0, "t3_b0");

    // Full A: push with concurrent pop is refused, pop still happens
    step(1'b1, 1'b1, 32'hA2, 1'b1, 1'b0, "t4_full_pushpop");
    check("t4_a_count", 32'(a_count), 32'd1);
    check("t4_a_data",  a_data, 32'hA1);
    step(1'b1, 1'b1, 32'hA3, 1'b1, 1'b0, "t4_pushpop_notfull");
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "t4_drain1");
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "t4_drain2");

    // Sustained alternating stream
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'(i % 2), 32'h5000_0000 + 32'(i), 1'b1, 1'b1, "t5_stream");
      assert (a_count <= 1 && b_count <= 1) else begin
        miscompares++;
        $error("FAIL t5_count_bound: observed a=%0d b=%0d expected <=1", a_count, b_count);
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "t5_drain");

    // Reset with data in flight, then a fresh beat
    step(1'b1, 1'b1, 32'hC0, 1'b0, 1'b0, "t6_fill_a0");
    step(1'b1, 1'b1, 32'hC1, 1'b0, 1'b0, "t6_fill_a1");
    step(1'b1, 1'b0, 32'hD0, 1'b0, 1'b0, "t6_fill_b0");
    check("t6_pre_a_count", 32'(a_count), 32'd2);
    check("t6_pre_b_count", 32'(b_count), 32'd1);
    do_reset("t6_reset");
    check("t6_a_data_zero", a_data, 32'h0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "t6_post_push");
    check("t6_post_a_data", a_data, 32'hDEAD_BEEF);

    // Randomized traffic with a reset in the middle
    for (int i = 0; i < 300; i++) begin
      if (i == 150)
        do_reset("rnd_reset");
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
